// File: rtl/result_stream_pkg.sv
// Shared constants for the product register file read path: state encoding and default geometry.
package result_stream_pkg;

    localparam int unsigned RS_NUM_REGS = 8;
    localparam int unsigned RS_DATA_W   = 8;
    localparam int unsigned STATE_W     = 2;

    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] STREAM = 2'd1;
    localparam logic [STATE_W-1:0] CHKSUM = 2'd2;
    localparam logic [STATE_W-1:0] FINISH = 2'd3;

endpackage

// File: rtl/result_streamer.sv
// Snapshots the packed product bus on start and streams one entry per valid/ready handshake.
// Optional trailing XOR checksum beat when RESULT_CHECKSUM_EN is defined.
module result_streamer
    import result_stream_pkg::*;
#(
    parameter int unsigned NUM_REGS = RS_NUM_REGS,
    parameter int unsigned DATA_W   = RS_DATA_W,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_REGS*DATA_W-1:0] contents,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [STATE_W-1:0]                 state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d, idx_inc;
    logic [NUM_REGS-1:0][DATA_W-1:0]    snap_q, snap_d;
    logic [DATA_W-1:0]                  data_q, data_d;
    logic [IDX_W-1:0]                   index_q, index_d;
    logic                               valid_q, valid_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               xfer;

    assign xfer = valid_q && out_ready;

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] chksum;

    // XOR fold of the held snapshot, offered as the trailing beat
    always_comb begin
        chksum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            chksum = chksum ^ snap_q[IDX_W'(i)];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_inc = idx_q + IDX_W'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = contents;
                    idx_d   = '0;
                    data_d  = contents[DATA_W-1:0];
                    index_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
`ifdef RESULT_CHECKSUM_EN
                        data_d  = chksum;
                        index_d = '0;
                        state_d = CHKSUM;
`else
                        data_d  = '0;
                        index_d = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
`endif
                    end else begin
                        // next entry is registered on the accepting edge, so no bubble
                        idx_d   = idx_inc;
                        data_d  = snap_q[idx_inc];
                        index_d = idx_inc;
                    end
                end
            end
`ifdef RESULT_CHECKSUM_EN
            CHKSUM: begin
                if (xfer) begin
                    data_d  = '0;
                    index_d = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
